// File: rtl/mem_pkg.sv
// Shared definitions for the memory-stage responder: FSM states, RV32I
// load/store funct3 codes and request legality helpers.
package mem_pkg;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  // funct3[1:0] encodes access size for every legal code (00 byte, 01 half, 10 word).
  function automatic logic f3_aligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b01:   return !a[0];
      2'b10:   return a == 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ram_1rw.sv
// Single-port word RAM: synchronous write, synchronous 1-cycle read.
// Read data holds until the next read, which the responder's RMW path relies on.
module ram_1rw #(
  parameter int DW    = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem_q[addr] <= wdata;
      else    rdata_q     <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-stage responder: latches one load/store request, runs it against a
// single-port RAM (read-modify-write for sub-word stores) and emits one response strobe.
module mem_responder
  import mem_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_e           state_q, state_d;
  logic             we_q, we_d;
  logic [2:0]       f3_q, f3_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  logic             ram_en, ram_we;
  logic [AW-1:0]    ram_addr;
  logic [WIDTH-1:0] ram_rdata, st_word, ld_data;
  logic [7:0]       ld_byte;
  logic [15:0]      ld_half;
  logic             unused_addr;

  assign unused_addr = ^addr_q[WIDTH-1:AW+2];

  ram_1rw #(.DW(WIDTH), .DEPTH(DEPTH_WORDS)) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(st_word),
    .rdata(ram_rdata)
  );

  // Lane extract for loads and lane merge for stores, both from the held RAM word.
  always_comb begin
    ld_byte = ram_rdata[{addr_q[1:0], 3'b000} +: 8];
    ld_half = ram_rdata[{addr_q[1], 4'b0000} +: 16];
    case (f3_q)
      F3_LB:   ld_data = {{(WIDTH-8){ld_byte[7]}}, ld_byte};
      F3_LH:   ld_data = {{(WIDTH-16){ld_half[15]}}, ld_half};
      F3_LBU:  ld_data = {{(WIDTH-8){1'b0}}, ld_byte};
      F3_LHU:  ld_data = {{(WIDTH-16){1'b0}}, ld_half};
      default: ld_data = ram_rdata;
    endcase
    st_word = ram_rdata;
    case (f3_q)
      F3_SB:   st_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      F3_SH:   st_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: st_word = wdata_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    f3_d        = f3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    rsp_rdata_d = rsp_rdata_q;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = addr_q[AW+1:2];
    req_ready   = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        ram_addr  = req_addr[AW+1:2];
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (!f3_legal(req_we, req_funct3) || !f3_aligned(req_funct3, req_addr[1:0])) begin
            err_d       = 1'b1;
            rsp_rdata_d = '0;
            state_d     = RESP;
          end else begin
            err_d = 1'b0;
            if (req_we && req_funct3 == F3_SW) begin
              state_d = WRITE;
            end else begin
              ram_en  = 1'b1;
              state_d = READ;
            end
          end
        end
      end
      READ: begin
        if (we_q) begin
          state_d = WRITE;
        end else begin
          rsp_rdata_d = ld_data;
          state_d     = RESP;
        end
      end
      WRITE: begin
        // Gated by rst so an aborted store never lands in memory.
        ram_en      = !rst;
        ram_we      = !rst;
        rsp_rdata_d = '0;
        state_d     = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      f3_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = (state_q == RESP) && err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: each accepted request pushes its expected
// response and cycle; a negedge monitor pops and compares every rsp_valid strobe.
module tb_mem_responder;

  localparam int DEPTH = 1024;
  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  mem_responder #(.WIDTH(32), .DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rsp_valid) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL rsp_unexpected: rsp_valid=1 rdata=%h with no pending request", rsp_rdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (rsp_rdata !== e.rdata || rsp_err !== e.err || cyc !== e.cyc) begin
          fails++;
          $display("FAIL rsp_check: got rdata=%h err=%b cyc=%0d, want rdata=%h err=%b cyc=%0d",
                   rsp_rdata, rsp_err, cyc, e.rdata, e.err, e.cyc);
        end
      end
    end
  end

  task automatic wait_ready(output bit ok);
    int guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    ok = req_ready;
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: req_ready=%b, want 1", req_ready);
    end
  endtask

  // lat = cycles from the negedge before acceptance to the response negedge.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] erd, input logic eerr,
                       input int lat, output int acc);
    bit ok;
    exp_t e;
    wait_ready(ok);
    acc = -1;
    if (!ok) return;
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    e.rdata = erd; e.err = eerr; e.cyc = cyc + lat;
    sb.push_back(e);
    acc = cyc;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++;
    if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", rsp_valid); end
    tests++;
    if (rsp_err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", rsp_err); end
    tests++;
    if (rsp_rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h want 0", rsp_rdata); end
    tests++;
    if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    rst = 1'b0;
  endtask

  task automatic test_word();
    int a;
    issue(1, SW, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2, a);
    issue(0, LW, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2, a);
  endtask

  task automatic test_subword();
    int a;
    issue(1, SB, 32'h11, 32'h55, 32'h0, 0, 3, a);
    issue(0, LW, 32'h10, 32'h0, 32'hDEAD55EF, 0, 2, a);
    issue(0, LB, 32'h13, 32'h0, 32'hFFFFFFDE, 0, 2, a);
    issue(0, LBU, 32'h13, 32'h0, 32'h000000DE, 0, 2, a);
    issue(0, LB, 32'h10, 32'h0, 32'hFFFFFFEF, 0, 2, a);
    issue(0, LH, 32'h10, 32'h0, 32'h000055EF, 0, 2, a);
    issue(0, LHU, 32'h12, 32'h0, 32'h0000DEAD, 0, 2, a);
    issue(1, SW, 32'h20, 32'h1234CAFE, 32'h0, 0, 2, a);
    issue(1, SH, 32'h22, 32'hFFFF8001, 32'h0, 0, 3, a);
    issue(0, LH, 32'h22, 32'h0, 32'hFFFF8001, 0, 2, a);
    issue(0, LHU, 32'h22, 32'h0, 32'h00008001, 0, 2, a);
    issue(0, LW, 32'h20, 32'h0, 32'h8001CAFE, 0, 2, a);
  endtask

  task automatic test_errors();
    int a;
    issue(0, LW, 32'h11, 32'h0, 32'h0, 1, 1, a);
    issue(1, SH, 32'h13, 32'hBEEF, 32'h0, 1, 1, a);
    issue(0, 3'b011, 32'h10, 32'h0, 32'h0, 1, 1, a);
    issue(1, 3'b100, 32'h20, 32'h99, 32'h0, 1, 1, a);
    issue(0, LH, 32'h21, 32'h0, 32'h0, 1, 1, a);
    issue(0, LW, 32'h10, 32'h0, 32'hDEAD55EF, 0, 2, a);
    issue(0, LW, 32'h20, 32'h0, 32'h8001CAFE, 0, 2, a);
  endtask

  // Request stays valid while the responder is busy; new fields must wait for IDLE.
  task automatic test_busy();
    bit ok;
    int n;
    exp_t e;
    wait_ready(ok);
    if (!ok) return;
    req_we = 0; req_funct3 = LW; req_addr = 32'h20; req_valid = 1'b1;
    n = cyc;
    e.rdata = 32'h8001CAFE; e.err = 0; e.cyc = n + 2;
    sb.push_back(e);
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b0) begin fails++; $display("FAIL busy_ready_read: got %b want 0", req_ready); end
    req_funct3 = LBU; req_addr = 32'h10;
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b0) begin fails++; $display("FAIL busy_ready_resp: got %b want 0", req_ready); end
    e.rdata = 32'h000000EF; e.err = 0; e.cyc = n + 5;
    sb.push_back(e);
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1) begin fails++; $display("FAIL busy_ready_idle: got %b want 1", req_ready); end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic test_reset_abort();
    bit ok;
    int a;
    issue(1, SW, 32'h30, 32'h11223344, 32'h0, 0, 2, a);
    wait_ready(ok);
    if (!ok) return;
    req_we = 1; req_funct3 = SB; req_addr = 32'h30; req_wdata = 32'hAA; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (rsp_valid !== 1'b0) begin fails++; $display("FAIL abort_valid: got %b want 0", rsp_valid); end
    tests++;
    if (req_ready !== 1'b1) begin fails++; $display("FAIL abort_ready: got %b want 1", req_ready); end
    rst = 1'b0;
    issue(0, LW, 32'h30, 32'h0, 32'h11223344, 0, 2, a);
  endtask

  task automatic test_wrap();
    int a;
    issue(1, SW, DEPTH * 4 + 4, 32'h12345678, 32'h0, 0, 2, a);
    issue(0, LW, 32'h4, 32'h0, 32'h12345678, 0, 2, a);
  endtask

  task automatic test_back_to_back();
    int a0, a1, a2, s0, s1;
    issue(0, LW, 32'h10, 32'h0, 32'hDEAD55EF, 0, 2, a0);
    issue(0, LW, 32'h20, 32'h0, 32'h8001CAFE, 0, 2, a1);
    issue(0, LW, 32'h4, 32'h0, 32'h12345678, 0, 2, a2);
    tests++;
    if (a1 - a0 !== 3 || a2 - a1 !== 3) begin
      fails++;
      $display("FAIL load_throughput: spacing %0d,%0d want 3,3", a1 - a0, a2 - a1);
    end
    issue(1, SB, 32'h21, 32'h77, 32'h0, 0, 3, s0);
    issue(1, SB, 32'h20, 32'h66, 32'h0, 0, 3, s1);
    tests++;
    if (s1 - s0 !== 4) begin
      fails++;
      $display("FAIL store_throughput: spacing %0d want 4", s1 - s0);
    end
    issue(0, LW, 32'h20, 32'h0, 32'h80017766, 0, 2, a0);
  endtask

  initial begin
    int guard;
    test_reset();
    test_word();
    test_subword();
    test_errors();
    test_busy();
    test_reset_abort();
    test_wrap();
    test_back_to_back();
    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    repeat (2) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d responses outstanding, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
